// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between the core (M0) and an
// auxiliary master (M1), with a per-transaction timeout abort.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_resp,
  output logic                    m0_err,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_resp,
  output logic                    m1_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    busy,
  output logic                    grant
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e                  state_q;
  logic                    rr_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [BW-1:0]           mem_be_q;
  logic [DATA_WIDTH-1:0]   m0_rdata_q;
  logic [DATA_WIDTH-1:0]   m1_rdata_q;
  logic                    m0_resp_q;
  logic                    m1_resp_q;
  logic                    m0_err_q;
  logic                    m1_err_q;
  logic                    busy_q;
  logic                    grant_q;

  logic                    req0;
  logic                    req1;
  logic                    pick1;
  logic                    sel_rd;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [BW-1:0]           sel_be;
  logic                    to_hit;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // rr_q=1 means the round-robin pointer favours M1
  assign pick1 = req1 & (~req0 | ((FIXED_PRIO == 0) & rr_q));

  assign sel_rd    = pick1 ? m1_read  : m0_read;
  assign sel_wr    = pick1 ? m1_write : m0_write;
  assign sel_addr  = pick1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick1 ? m1_wdata : m0_wdata;
  assign sel_be    = pick1 ? m1_be    : m0_be;

  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_resp_q   <= 1'b0;
      m1_resp_q   <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req0 | req1) begin
            mem_read_q  <= sel_rd & ~sel_wr;
            mem_write_q <= sel_wr;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_be_q    <= sel_be;
            grant_q     <= pick1;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (grant_q) m1_rdata_q <= mem_rdata;
            else         m0_rdata_q <= mem_rdata;
            m0_resp_q   <= ~grant_q;
            m1_resp_q   <= grant_q;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            state_q     <= S_RESP;
          end else if (to_hit) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (grant_q) m1_rdata_q <= '0;
            else         m0_rdata_q <= '0;
            m0_resp_q   <= ~grant_q;
            m1_resp_q   <= grant_q;
            m0_err_q    <= ~grant_q;
            m1_err_q    <= grant_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          m0_resp_q <= 1'b0;
          m1_resp_q <= 1'b0;
          m0_err_q  <= 1'b0;
          m1_err_q  <= 1'b0;
          busy_q    <= 1'b0;
          rr_q      <= ~grant_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_resp   = m0_resp_q;
  assign m1_resp   = m1_resp_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; both use a short timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_resp, m0_err, m1_resp, m1_err;
  logic        mem_read, mem_write, busy, grant;
  logic [3:0]  mem_be;

  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_m0_resp, fp_m0_err, fp_m1_resp, fp_m1_err;
  logic        fp_mem_read, fp_mem_write, fp_busy, fp_grant;
  logic [3:0]  fp_mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4)) u_rr (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_rdata(m0_rdata),
    .m0_resp(m0_resp), .m0_err(m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_rdata(m1_rdata),
    .m1_resp(m1_resp), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy), .grant(grant)
  );

  mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4)) u_fp (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_rdata(fp_m0_rdata),
    .m0_resp(fp_m0_resp), .m0_err(fp_m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_rdata(fp_m1_rdata),
    .m1_resp(fp_m1_resp), .m1_err(fp_m1_err),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_be(fp_mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(fp_busy), .grant(fp_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_read = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    mem_rdata = '0; mem_resp = 0;
    tick();
    tick();
    checks++;
    if ({mem_read, mem_write, busy, grant} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {mem_read, mem_write, busy, grant});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      errors++;
      $display("FAIL reset_cmd: got %h want 0", {mem_addr, mem_wdata, mem_be});
    end
    checks++;
    if ({m0_resp, m0_err, m1_resp, m1_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_resp: got %b want 0000",
               {m0_resp, m0_err, m1_resp, m1_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    m0_read = 1; m0_addr = 32'h1000;
    tick();
    checks++;
    if ({mem_read, mem_write, busy, grant} !== 4'b1010 ||
        mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL m0rd_c1: got rd/wr/busy/gnt=%b addr=%h want 1010 1000",
               {mem_read, mem_write, busy, grant}, mem_addr);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL m0rd_c2: got mem_read=%b want 1", mem_read);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || m0_resp !== 1'b0) begin
      errors++;
      $display("FAIL m0rd_c3: got mem_read=%b m0_resp=%b want 1 0",
               mem_read, m0_resp);
    end
    mem_resp = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({m0_resp, m0_err, m1_resp, mem_read} !== 4'b1000 ||
        m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL m0rd_c4: got resp/err/m1resp/rd=%b rdata=%h want 1000 deadbeef",
               {m0_resp, m0_err, m1_resp, mem_read}, m0_rdata);
    end
    mem_resp = 0; m0_read = 0; mem_rdata = 32'h0;
    tick();
    checks++;
    if (m0_resp !== 1'b0 || busy !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL m0rd_c5: got resp=%b busy=%b rdata=%h want 0 0 deadbeef",
               m0_resp, busy, m0_rdata);
    end
  endtask

  task automatic test_fixed_prio();
    pulse_rst();
    m0_read = 1; m0_addr = 32'h1000;
    m1_write = 1; m1_addr = 32'h2000; m1_wdata = 32'h12345678; m1_be = 4'b0011;
    mem_resp = 1; mem_rdata = 32'h0F0F0F0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fp_grant !== 1'b0 || fp_mem_read !== 1'b1 ||
          fp_mem_addr !== 32'h1000) begin
        errors++;
        $display("FAIL fp_grant%0d: got gnt=%b rd=%b addr=%h want 0 1 1000",
                 i, fp_grant, fp_mem_read, fp_mem_addr);
      end
      tick();
      checks++;
      if (fp_m0_resp !== 1'b1 || fp_m1_resp !== 1'b0) begin
        errors++;
        $display("FAIL fp_resp%0d: got m0=%b m1=%b want 1 0",
                 i, fp_m0_resp, fp_m1_resp);
      end
      tick();
    end
    m0_read = 0; m1_write = 0; mem_resp = 0;
    tick();
  endtask

  task automatic test_round_robin();
    bit exp1;
    pulse_rst();
    m0_read = 1; m0_addr = 32'h1000;
    m1_write = 1; m1_addr = 32'h2000; m1_wdata = 32'h12345678; m1_be = 4'b0011;
    mem_resp = 1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2) == 1;
      tick();
      checks++;
      if (grant !== exp1) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp1);
      end
      checks++;
      if (exp1) begin
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h2000 ||
            mem_wdata !== 32'h12345678 || mem_be !== 4'b0011) begin
          errors++;
          $display("FAIL rr_cmd%0d: got rw=%b a=%h d=%h be=%b want 01 2000 12345678 0011",
                   i, {mem_read, mem_write}, mem_addr, mem_wdata, mem_be);
        end
      end else begin
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h1000) begin
          errors++;
          $display("FAIL rr_cmd%0d: got rw=%b a=%h want 10 1000",
                   i, {mem_read, mem_write}, mem_addr);
        end
      end
      tick();
      checks++;
      if (m0_resp !== !exp1 || m1_resp !== exp1) begin
        errors++;
        $display("FAIL rr_resp%0d: got m0=%b m1=%b want %b %b",
                 i, m0_resp, m1_resp, !exp1, exp1);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: got busy=%b want 0", i, busy);
      end
    end
    m0_read = 0; m1_write = 0; mem_resp = 0;
    tick();
  endtask

  task automatic test_timeout();
    checks++;
    if (m1_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL to_pre: got m1_rdata=%h want cafef00d", m1_rdata);
    end
    m1_read = 1; m1_addr = 32'h3000; mem_resp = 0; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_read !== 1'b1 || grant !== 1'b1 || m1_resp !== 1'b0) begin
        errors++;
        $display("FAIL to_busy%0d: got rd=%b gnt=%b resp=%b want 1 1 0",
                 i, mem_read, grant, m1_resp);
      end
    end
    tick();
    checks++;
    if ({mem_read, m1_resp, m1_err, m0_resp, busy} !== 5'b01101 ||
        m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_resp: got rd/resp/err/m0resp/busy=%b rdata=%h want 01101 0",
               {mem_read, m1_resp, m1_err, m0_resp, busy}, m1_rdata);
    end
    m1_read = 0;
    tick();
    checks++;
    if ({busy, m1_resp, m1_err} !== 3'b000) begin
      errors++;
      $display("FAIL to_idle: got busy/resp/err=%b want 000",
               {busy, m1_resp, m1_err});
    end
    m0_write = 1; m0_addr = 32'h4000; m0_wdata = 32'hAAAA5555; m0_be = 4'hF;
    tick();
    checks++;
    if ({mem_write, mem_read, grant} !== 3'b100 || mem_addr !== 32'h4000) begin
      errors++;
      $display("FAIL to_next: got wr/rd/gnt=%b addr=%h want 100 4000",
               {mem_write, mem_read, grant}, mem_addr);
    end
    mem_resp = 1;
    tick();
    checks++;
    if (m0_resp !== 1'b1 || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL to_next_resp: got resp=%b err=%b want 1 0", m0_resp, m0_err);
    end
    m0_write = 0; mem_resp = 0;
    tick();
  endtask

  task automatic test_both_rw();
    m0_read = 1; m0_write = 1; m0_addr = 32'h5000;
    tick();
    checks++;
    if ({mem_read, mem_write} !== 2'b01) begin
      errors++;
      $display("FAIL rw_cmd: got rd/wr=%b want 01", {mem_read, mem_write});
    end
    mem_resp = 1;
    tick();
    checks++;
    if (m0_resp !== 1'b1) begin
      errors++;
      $display("FAIL rw_resp: got %b want 1", m0_resp);
    end
    m0_read = 0; m0_write = 0; mem_resp = 0;
    tick();
  endtask

  task automatic test_idle_resp();
    mem_resp = 1; mem_rdata = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({m0_resp, m1_resp, busy, mem_read, mem_write} !== 5'b0) begin
        errors++;
        $display("FAIL idle_resp%0d: got %b want 00000", i,
                 {m0_resp, m1_resp, busy, mem_read, mem_write});
      end
    end
    mem_resp = 0;
    tick();
  endtask

  task automatic test_reset_busy();
    m0_read = 1; m0_addr = 32'h6000;
    tick();
    checks++;
    if (mem_read !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy: got rd=%b busy=%b want 1 1", mem_read, busy);
    end
    rst = 1;
    tick();
    checks++;
    if ({mem_read, busy, grant, m0_resp} !== 4'b0) begin
      errors++;
      $display("FAIL rb_rst: got rd/busy/gnt/resp=%b want 0000",
               {mem_read, busy, grant, m0_resp});
    end
    rst = 0;
    tick();
    checks++;
    if (mem_read !== 1'b1 || m0_resp !== 1'b0 || mem_addr !== 32'h6000) begin
      errors++;
      $display("FAIL rb_fresh: got rd=%b resp=%b addr=%h want 1 0 6000",
               mem_read, m0_resp, mem_addr);
    end
    mem_resp = 1; mem_rdata = 32'h0BADF00D;
    tick();
    checks++;
    if (m0_resp !== 1'b1 || m0_rdata !== 32'h0BADF00D || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL rb_done: got resp=%b rdata=%h err=%b want 1 0badf00d 0",
               m0_resp, m0_rdata, m0_err);
    end
    m0_read = 0; mem_resp = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rb_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_fixed_prio();
    test_round_robin();
    test_timeout();
    test_both_rw();
    test_idle_resp();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
